// File: rtl/rst_seq_gen_pkg.sv
// Shared types, defaults and width helper for the staged reset sequencer.
package rst_seq_pkg;

  localparam int DEF_STAGES      = 3;
  localparam int DEF_SYNC_DEPTH  = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES  = 4;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2,
    RUN  = 2'd3
  } seq_state_e;

  // A count limit of 1 would give a zero-width counter, so keep at least one bit.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Software reset request and staged reset outputs of one clock domain.
interface rst_seq_gen_if #(
  parameter int STAGES = 3
);
  logic              sw_rst_req;
  logic [STAGES-1:0] rst_out_n;
  logic              ready;
  logic              busy;

  modport master (
    input  sw_rst_req,
    output rst_out_n,
    output ready,
    output busy
  );

  modport slave (
    output sw_rst_req,
    input  rst_out_n,
    input  ready,
    input  busy
  );
endinterface

// File: rtl/rst_seq_gen_sync_cell.sv
// Async-assert / sync-deassert chain for the board reset release.
module rst_sync_cell #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic R,
  output logic sync_out
);

  logic [SYNC_DEPTH-1:0] chain;

  always_ff @(posedge clk or negedge R) begin
    if (!R) chain <= '0;
    else    chain <= {chain[SYNC_DEPTH-2:0], 1'b1};
  end

  assign sync_out = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: async assert on R low, hold, then release stages in order.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int SYNC_DEPTH  = DEF_SYNC_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic          clk,
  input  logic          R,
  rst_seq_gen_if.master bus
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = $clog2(STAGES + 1);

  localparam logic [1:0] ST_SYNC = SYNC;
  localparam logic [1:0] ST_HOLD = HOLD;
  localparam logic [1:0] ST_REL  = REL;
  localparam logic [1:0] ST_RUN  = RUN;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(STAGES - 1);

  logic              sync_q;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [STAGES-1:0] rst_q;
  logic              ready_q;
  logic              busy_q;

  rst_sync_cell #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
    .clk      (clk),
    .R        (R),
    .sync_out (sync_q)
  );

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state   <= ST_SYNC;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (state == ST_SYNC) begin
      if (sync_q) begin
        state  <= ST_HOLD;
        cnt    <= '0;
        busy_q <= 1'b1;
      end
    end else if (bus.sw_rst_req) begin
      // Software request restarts the hold from scratch every cycle it is seen.
      state   <= ST_HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_q[0] <= 1'b1;
            cnt      <= '0;
            if (STAGES == 1) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state <= ST_REL;
              idx   <= IW'(1);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REL: begin
          if (cnt == GAP_LAST) begin
            rst_q[idx] <= 1'b1;
            cnt        <= '0;
            if (idx == LAST_IDX) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rst_out_n = rst_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench: default sequencer plus a minimal-parameter instance sharing clk/R.
module tb_rst_seq_gen;

  logic clk;
  logic R;
  int   n_tests;
  int   n_fail;

  rst_seq_gen_if #(.STAGES(3)) bus0 ();
  rst_seq_gen_if #(.STAGES(1)) bus1 ();

  rst_seq_gen #(.STAGES(3), .SYNC_DEPTH(2), .HOLD_CYCLES(16), .GAP_CYCLES(4)) u_dut (
    .clk (clk),
    .R   (R),
    .bus (bus0.master)
  );

  rst_seq_gen #(.STAGES(1), .SYNC_DEPTH(3), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_dut_min (
    .clk (clk),
    .R   (R),
    .bus (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected staged pattern when stage 0 releases at edge b and stages are 4 apart.
  function automatic logic [2:0] exp_rst(input int e, input int b);
    return {e >= b + 8, e >= b + 4, e >= b};
  endfunction

  // Called just after R rises, before edge 1.
  task automatic run_seq(input string tag, input bit sw_in_sync);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      chk($sformatf("%s rst e%0d", tag, e),   32'(bus0.rst_out_n), 32'(exp_rst(e, 19)));
      chk($sformatf("%s ready e%0d", tag, e), 32'(bus0.ready),     32'(e >= 27));
      chk($sformatf("%s busy e%0d", tag, e),  32'(bus0.busy),      32'(e >= 3 && e <= 26));
      chk($sformatf("%s min rst e%0d", tag, e),   32'(bus1.rst_out_n), 32'(e >= 5));
      chk($sformatf("%s min ready e%0d", tag, e), 32'(bus1.ready),     32'(e >= 5));
      chk($sformatf("%s min busy e%0d", tag, e),  32'(bus1.busy),      32'(e == 4));
      if (sw_in_sync && e == 3) bus0.sw_rst_req = 1'b0;
    end
  endtask

  // Edges counted from the last edge that sampled sw_rst_req high.
  task automatic sw_follow(input string tag, input int last_j);
    for (int j = 1; j <= last_j; j++) begin
      @(posedge clk); #1;
      chk($sformatf("%s rst j%0d", tag, j),   32'(bus0.rst_out_n), 32'(exp_rst(j, 16)));
      chk($sformatf("%s ready j%0d", tag, j), 32'(bus0.ready),     32'(j >= 24));
      chk($sformatf("%s busy j%0d", tag, j),  32'(bus0.busy),      32'(j < 24));
    end
  endtask

  task automatic sw_edge(input string tag);
    chk({tag, " rst"},   32'(bus0.rst_out_n), 32'd0);
    chk({tag, " ready"}, 32'(bus0.ready),     32'd0);
    chk({tag, " busy"},  32'(bus0.busy),      32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    R = 1'b0;
    bus0.sw_rst_req = 1'b0;
    bus1.sw_rst_req = 1'b0;

    #3;
    chk("reset rst",       32'(bus0.rst_out_n), 32'd0);
    chk("reset ready",     32'(bus0.ready),     32'd0);
    chk("reset busy",      32'(bus0.busy),      32'd0);
    chk("reset min rst",   32'(bus1.rst_out_n), 32'd0);
    chk("reset min ready", 32'(bus1.ready),     32'd0);
    chk("reset min busy",  32'(bus1.busy),      32'd0);

    // Power-up; a request held through SYNC must be ignored.
    repeat (5) @(posedge clk);
    @(negedge clk);
    R = 1'b1;
    bus0.sw_rst_req = 1'b1;
    run_seq("pwr", 1'b1);

    // Async assertion mid-cycle while in RUN.
    @(posedge clk); #5;
    R = 1'b0;
    #1;
    chk("async rst",   32'(bus0.rst_out_n), 32'd0);
    chk("async ready", 32'(bus0.ready),     32'd0);
    chk("async busy",  32'(bus0.busy),      32'd0);
    #2;
    @(negedge clk);
    R = 1'b1;
    run_seq("async", 1'b0);

    // One-cycle software pulse in RUN.
    @(negedge clk);
    bus0.sw_rst_req = 1'b1;
    @(posedge clk); #1;
    sw_edge("sw E");
    bus0.sw_rst_req = 1'b0;
    sw_follow("sw", 26);

    // Request when rst_out_n = 011, held for 10 sampled edges.
    @(negedge clk);
    bus0.sw_rst_req = 1'b1;
    @(posedge clk); #1;
    sw_edge("mid E");
    bus0.sw_rst_req = 1'b0;
    sw_follow("mid", 20);
    bus0.sw_rst_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      sw_edge($sformatf("hold k%0d", k));
    end
    bus0.sw_rst_req = 1'b0;
    sw_follow("hold10", 26);

    // R glitch of 3 ns after 8 hold cycles.
    @(negedge clk);
    bus0.sw_rst_req = 1'b1;
    @(posedge clk); #1;
    bus0.sw_rst_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("glitch pre rst",  32'(bus0.rst_out_n), 32'd0);
    chk("glitch pre busy", 32'(bus0.busy),      32'd1);
    #1;
    R = 1'b0;
    #1;
    chk("glitch rst",   32'(bus0.rst_out_n), 32'd0);
    chk("glitch ready", 32'(bus0.ready),     32'd0);
    chk("glitch busy",  32'(bus0.busy),      32'd0);
    #2;
    R = 1'b1;
    run_seq("glitch", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
